// File: rtl/elevator_scan_controller.sv
// SCAN elevator controller: latches floor calls, sweeps in one direction until no calls remain ahead.
// Optional emergency stop (i_estop port, HALT state) is compiled in when ELEVATOR_ESTOP_EN is defined.
module elevator_scan_controller #(
    parameter int unsigned NUM_FLOORS = 8,
    parameter int unsigned MOVE_TICKS = 10000000,
    parameter int unsigned DOOR_TICKS = 5000000,
    localparam int unsigned FLOOR_W   = 4
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
`ifdef ELEVATOR_ESTOP_EN
    input  logic                  i_estop,
`endif
    input  logic [NUM_FLOORS-1:0] i_req,
    output logic [NUM_FLOORS-1:0] o_pending,
    output logic [FLOOR_W-1:0]    o_current_floor,
    output logic                  o_dir_up,
    output logic                  o_moving,
    output logic                  o_door_open,
    output logic                  o_idle
);

    localparam int unsigned TICK_MAX = (MOVE_TICKS > DOOR_TICKS) ? MOVE_TICKS : DOOR_TICKS;
    localparam int unsigned TIMER_W  = $clog2(TICK_MAX);
    localparam logic [TIMER_W-1:0] MOVE_LAST = TIMER_W'(MOVE_TICKS - 1);
    localparam logic [TIMER_W-1:0] DOOR_LAST = TIMER_W'(DOOR_TICKS - 1);

`ifdef ELEVATOR_ESTOP_EN
    typedef enum logic [2:0] {S_IDLE, S_MOVE_UP, S_MOVE_DOWN, S_DOOR_OPEN, S_HALT} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_MOVE_UP, S_MOVE_DOWN, S_DOOR_OPEN} state_t;
`endif

    state_t                r_state, w_state_n;
    logic [FLOOR_W-1:0]    r_floor, w_floor_n, w_floor_step;
    logic                  r_dir_up, w_dir_n;
    logic [TIMER_W-1:0]    r_timer, w_timer_n;
    logic [NUM_FLOORS-1:0] r_pending, w_pending_n, w_set, w_clr;
    logic [NUM_FLOORS-1:0] w_oh_here, w_oh_step;
    logic                  w_hit_here, w_hit_step;
    logic [1:0]            w_scan_here, w_scan_step;
    logic                  r_moving, r_door_open, r_idle;

    function automatic logic [NUM_FLOORS-1:0] onehot(input logic [FLOOR_W-1:0] f);
        onehot = '0;
        for (int unsigned i = 0; i < NUM_FLOORS; i++)
            onehot[i] = (FLOOR_W'(i) == f);
    endfunction

    // Returns {go, up}: keep the current direction while calls lie ahead, else reverse, else stop.
    function automatic logic [1:0] scan_dir(input logic [NUM_FLOORS-1:0] p,
                                            input logic [FLOOR_W-1:0] f, input logic up);
        logic above;
        logic below;
        above = 1'b0;
        below = 1'b0;
        for (int unsigned i = 0; i < NUM_FLOORS; i++) begin
            if (FLOOR_W'(i) > f) above = above | p[i];
            if (FLOOR_W'(i) < f) below = below | p[i];
        end
        if (up && above)       scan_dir = 2'b11;
        else if (!up && below) scan_dir = 2'b10;
        else if (above)        scan_dir = 2'b11;
        else if (below)        scan_dir = 2'b10;
        else                   scan_dir = {1'b0, up};
    endfunction

    assign w_floor_step = (r_state == S_MOVE_DOWN) ? r_floor - FLOOR_W'(1) : r_floor + FLOOR_W'(1);
    assign w_oh_here    = onehot(r_floor);
    assign w_oh_step    = onehot(w_floor_step);
    assign w_hit_here   = |(r_pending & w_oh_here);
    assign w_hit_step   = |(r_pending & w_oh_step);
    assign w_scan_here  = scan_dir(r_pending, r_floor, r_dir_up);
    assign w_scan_step  = scan_dir(r_pending, w_floor_step, r_dir_up);

    always_comb begin
        w_state_n = r_state;
        w_floor_n = r_floor;
        w_dir_n   = r_dir_up;
        w_timer_n = r_timer;
        w_set     = i_req;
        w_clr     = '0;
        case (r_state)
            S_IDLE: begin
                w_timer_n = '0;
                if (w_hit_here) begin
                    w_state_n = S_DOOR_OPEN;
                    w_clr     = w_oh_here;
                end else if (w_scan_here[1]) begin
                    w_dir_n   = w_scan_here[0];
                    w_state_n = w_scan_here[0] ? S_MOVE_UP : S_MOVE_DOWN;
                end
            end
            S_MOVE_UP, S_MOVE_DOWN: begin
                if (r_timer == MOVE_LAST) begin
                    w_timer_n = '0;
                    w_floor_n = w_floor_step;
                    if (w_hit_step) begin
                        w_state_n = S_DOOR_OPEN;
                        w_clr     = w_oh_step;
                    end else if (w_scan_step[1]) begin
                        w_dir_n   = w_scan_step[0];
                        w_state_n = w_scan_step[0] ? S_MOVE_UP : S_MOVE_DOWN;
                    end else begin
                        w_state_n = S_IDLE;
                    end
                end else begin
                    w_timer_n = r_timer + TIMER_W'(1);
                end
            end
            S_DOOR_OPEN: begin
                // A call for the floor we are standing at only extends the dwell.
                w_set = i_req & ~w_oh_here;
                if ((i_req & w_oh_here) != '0) begin
                    w_timer_n = '0;
                end else if (r_timer == DOOR_LAST) begin
                    w_timer_n = '0;
                    if (w_scan_here[1]) begin
                        w_dir_n   = w_scan_here[0];
                        w_state_n = w_scan_here[0] ? S_MOVE_UP : S_MOVE_DOWN;
                    end else begin
                        w_state_n = S_IDLE;
                    end
                end else begin
                    w_timer_n = r_timer + TIMER_W'(1);
                end
            end
`ifdef ELEVATOR_ESTOP_EN
            S_HALT: begin
                if (!i_estop) begin
                    w_state_n = S_IDLE;
                    w_timer_n = '0;
                end
            end
`endif
            default: w_state_n = S_IDLE;
        endcase
`ifdef ELEVATOR_ESTOP_EN
        if (i_estop) begin
            w_state_n = S_HALT;
            w_floor_n = r_floor;
            w_dir_n   = r_dir_up;
            w_timer_n = r_timer;
            w_set     = i_req;
            w_clr     = '0;
        end
`endif
        w_pending_n = (r_pending | w_set) & ~w_clr;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state     <= S_IDLE;
            r_floor     <= '0;
            r_dir_up    <= 1'b1;
            r_timer     <= '0;
            r_pending   <= '0;
            r_moving    <= 1'b0;
            r_door_open <= 1'b0;
            r_idle      <= 1'b1;
        end else begin
            r_state     <= w_state_n;
            r_floor     <= w_floor_n;
            r_dir_up    <= w_dir_n;
            r_timer     <= w_timer_n;
            r_pending   <= w_pending_n;
            r_moving    <= (w_state_n == S_MOVE_UP) || (w_state_n == S_MOVE_DOWN);
            r_door_open <= (w_state_n == S_DOOR_OPEN);
            r_idle      <= (w_state_n == S_IDLE);
        end
    end

    assign o_pending       = r_pending;
    assign o_current_floor = r_floor;
    assign o_dir_up        = r_dir_up;
    assign o_moving        = r_moving;
    assign o_door_open     = r_door_open;
    assign o_idle          = r_idle;

endmodule

// File: tb/tb_elevator_scan_controller.sv
// Bench for elevator_scan_controller (8 floors, 4-cycle travel, 3-cycle dwell).
// Expected door-open events are queued by the stimulus and matched by an independent monitor.
module tb_elevator_scan_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] req;
    logic       estop;
    logic [7:0] o_pending;
    logic [3:0] o_current_floor;
    logic       o_dir_up, o_moving, o_door_open, o_idle;

    typedef struct {
        logic [3:0] floor;
        logic       dir;
        int         len;
    } door_ev_t;

    door_ev_t exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    elevator_scan_controller #(.NUM_FLOORS(8), .MOVE_TICKS(4), .DOOR_TICKS(3)) dut (
        .i_clk          (clk),
        .i_reset        (reset),
`ifdef ELEVATOR_ESTOP_EN
        .i_estop        (estop),
`endif
        .i_req          (req),
        .o_pending      (o_pending),
        .o_current_floor(o_current_floor),
        .o_dir_up       (o_dir_up),
        .o_moving       (o_moving),
        .o_door_open    (o_door_open),
        .o_idle         (o_idle)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_ev(input logic [3:0] f, input logic d, input int l);
        door_ev_t e;
        e.floor = f;
        e.dir   = d;
        e.len   = l;
        exp_q.push_back(e);
    endtask

    // Called at a falling edge; request is sampled on the next rising edge.
    task automatic pulse_req(input logic [7:0] r);
        req = r;
        @(negedge clk);
        req = '0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n;
        n = 0;
        while (!(o_idle && !o_door_open && exp_q.size() == 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (!(o_idle && !o_door_open && exp_q.size() == 0)) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: not idle after %0d cycles, %0d door events outstanding", name, n, exp_q.size());
        end
    endtask

    task automatic wait_floor(input string name, input logic [3:0] f, input int budget);
        int n;
        n = 0;
        while (o_current_floor !== f && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(name, 32'(o_current_floor), 32'(f));
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_floor"},   32'(o_current_floor), 32'd0);
        chk({tag, "_idle"},    32'(o_idle),          32'd1);
        chk({tag, "_dir_up"},  32'(o_dir_up),        32'd1);
        chk({tag, "_pending"}, 32'(o_pending),       32'h00);
        chk({tag, "_door"},    32'(o_door_open),     32'd0);
        chk({tag, "_moving"},  32'(o_moving),        32'd0);
    endtask

    // Monitor: each door opening pops one expected event; its duration is checked on close.
    initial begin : monitor
        door_ev_t cur;
        logic     prev;
        int       len;
        bit       have;
        prev = 1'b0;
        len  = 0;
        have = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev = 1'b0;
                len  = 0;
                have = 1'b0;
            end else begin
                if (o_door_open && !prev) begin
                    len = 0;
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL door_unexpected: door opened at floor %0d, none expected", o_current_floor);
                    end else begin
                        cur  = exp_q.pop_front();
                        have = 1'b1;
                        chk("door_floor", 32'(o_current_floor), 32'(cur.floor));
                        chk("door_dir",   32'(o_dir_up),        32'(cur.dir));
                    end
                end
                if (o_door_open) len++;
                if (!o_door_open && prev && have) begin
                    chk("door_len", 32'(len), 32'(cur.len));
                    have = 1'b0;
                end
                prev = o_door_open;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int n;
        reset = 1'b1;
        req   = '0;
        estop = 1'b0;
        repeat (2) @(negedge clk);
        chk_reset_state("reset");
        reset = 1'b0;
        @(negedge clk);

        // Single call to floor 5 from floor 0.
        push_ev(4'd5, 1'b1, 3);
        pulse_req(8'h20);
        chk("latch_pending", 32'(o_pending), 32'h20);
        chk("latch_still_idle", 32'(o_idle), 32'd1);
        @(negedge clk);
        chk("move_at_n2", 32'(o_moving), 32'd1);
        n = 0;
        while (o_moving && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk("travel_cycles", 32'(n), 32'd20);
        wait_idle("trip_to_5", 100);
        chk("trip5_floor", 32'(o_current_floor), 32'd5);
        chk("trip5_pending", 32'(o_pending), 32'h00);

        // Reverse down to floor 2, then a call at the current floor with a dwell extension.
        push_ev(4'd2, 1'b0, 3);
        pulse_req(8'h04);
        wait_idle("trip_to_2", 100);
        chk("trip2_floor", 32'(o_current_floor), 32'd2);
        chk("trip2_dir", 32'(o_dir_up), 32'd0);
        push_ev(4'd2, 1'b0, 4);
        pulse_req(8'h04);
        chk("here_pending", 32'(o_pending), 32'h04);
        chk("here_door_n1", 32'(o_door_open), 32'd0);
        @(negedge clk);
        chk("here_door_n2", 32'(o_door_open), 32'd1);
        chk("here_floor", 32'(o_current_floor), 32'd2);
        chk("here_cleared", 32'(o_pending), 32'h00);
        pulse_req(8'h04);
        chk("dwell_no_pending", 32'(o_pending), 32'h00);
        wait_idle("dwell", 100);

        // Down to 0, then 6 with calls for 5 and 1 injected while passing floor 3.
        push_ev(4'd0, 1'b0, 3);
        pulse_req(8'h01);
        wait_idle("trip_to_0", 100);
        push_ev(4'd5, 1'b1, 3);
        push_ev(4'd6, 1'b1, 3);
        push_ev(4'd1, 1'b0, 3);
        pulse_req(8'h40);
        wait_floor("reach_3", 4'd3, 100);
        pulse_req(8'h22);
        chk("inject_pending", 32'(o_pending), 32'h62);
        wait_idle("scan", 300);
        chk("scan_floor", 32'(o_current_floor), 32'd1);
        chk("scan_dir", 32'(o_dir_up), 32'd0);
        chk("scan_pending", 32'(o_pending), 32'h00);

        // Asynchronous reset while travelling past floor 3 toward 7.
        pulse_req(8'h80);
        wait_floor("reach_3b", 4'd3, 100);
        chk("pre_reset_pending", 32'(o_pending), 32'h80);
        chk("pre_reset_moving", 32'(o_moving), 32'd1);
        #2 reset = 1'b1;
        #1 chk_reset_state("async_reset");
        @(negedge clk);
        push_ev(4'd3, 1'b1, 3);
        reset = 1'b0;
        pulse_req(8'h08);
        chk("release_latch", 32'(o_pending), 32'h08);
        wait_idle("after_reset", 100);
        chk("after_reset_floor", 32'(o_current_floor), 32'd3);

`ifdef ELEVATOR_ESTOP_EN
        // Emergency stop between floors 2 and 3 on the way up.
        push_ev(4'd0, 1'b0, 3);
        pulse_req(8'h01);
        wait_idle("estop_setup", 100);
        push_ev(4'd4, 1'b1, 3);
        push_ev(4'd5, 1'b1, 3);
        push_ev(4'd0, 1'b0, 3);
        pulse_req(8'h30);
        wait_floor("estop_reach_2", 4'd2, 100);
        @(negedge clk);
        estop = 1'b1;
        @(negedge clk);
        chk("halt_moving", 32'(o_moving), 32'd0);
        chk("halt_door", 32'(o_door_open), 32'd0);
        chk("halt_idle", 32'(o_idle), 32'd0);
        pulse_req(8'h01);
        chk("halt_latch", 32'(o_pending), 32'h31);
        repeat (5) @(negedge clk);
        chk("halt_floor", 32'(o_current_floor), 32'd2);
        chk("halt_still", 32'(o_moving), 32'd0);
        estop = 1'b0;
        @(negedge clk);
        chk("halt_release_idle", 32'(o_idle), 32'd1);
        wait_idle("estop_resume", 300);
        chk("estop_end_floor", 32'(o_current_floor), 32'd0);
        chk("estop_end_pending", 32'(o_pending), 32'h00);
`endif

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/elevator_scan_controller.md
ELEVATOR_SCAN_CONTROLLER -- requirements
Module: elevator_scan_controller

Interface
REQ-001 Parameter NUM_FLOORS, default 8, number of served floors (legal 2..16).
REQ-002 Parameter MOVE_TICKS, default 10000000, clk cycles to travel one floor (>=2).
REQ-003 Parameter DOOR_TICKS, default 5000000, clk cycles the door stays open (>=2).
REQ-004 Localparam FLOOR_W = 4, width of the floor index.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 req  input  NUM_FLOORS  floor call buttons; bit i high for >=1 cycle requests floor i.
REQ-008 pending  output  NUM_FLOORS  latched, not-yet-served requests.
REQ-009 current_floor  output  FLOOR_W  floor the car is at, binary.
REQ-010 dir_up  output  1  1 = current/last scan direction is up.
REQ-011 moving  output  1  high in MOVE_UP or MOVE_DOWN.
REQ-012 door_open  output  1  high in DOOR_OPEN.
REQ-013 idle  output  1  high in IDLE.

Function
REQ-014 States: IDLE, MOVE_UP, MOVE_DOWN, DOOR_OPEN (plus HALT per REQ-030); all outputs registered.
REQ-015 pending[i] sets the cycle after req[i] is sampled high; set is OR-ed, re-requests of a pending floor have no effect.
REQ-016 IDLE: pending[current_floor] set -> DOOR_OPEN next cycle, clearing that bit.
REQ-017 IDLE, else: pending bits in dir_up direction exist -> move that way; else pending bits in opposite direction -> flip dir_up and move; else stay IDLE.
REQ-018 Req-to-action latency from IDLE: req sampled cycle n, pending at n+1, state change at n+2.
REQ-019 Travel timer clears on entry to MOVE_*; when it reaches MOVE_TICKS-1, current_floor steps +-1 and timer clears.
REQ-020 On a floor step to floor f with pending[f] set: next state DOOR_OPEN, pending[f] cleared in same cycle; else keep moving if pending bits remain beyond f in dir_up direction, otherwise apply REQ-017.
REQ-021 current_floor never exceeds NUM_FLOORS-1 nor wraps below 0; movement only occurs toward a pending floor.
REQ-022 DOOR_OPEN lasts exactly DOOR_TICKS cycles, then applies REQ-017 (SCAN: continue current direction first).
REQ-023 req[current_floor] during DOOR_OPEN restarts the dwell timer and does not set pending.
REQ-024 Same-cycle set and clear of one pending bit: clear wins.
REQ-025 Requests for other floors are latched in every state, including during reset release cycle after reset deasserts.

Reset
REQ-026 reset high: state IDLE, current_floor 0, dir_up 1, pending 0, moving 0, door_open 0, idle 1, all timers 0.
REQ-027 Reset asserted mid-operation takes effect immediately (asynchronously); no partial state survives.

Configuration
REQ-028 Macro ELEVATOR_ESTOP_EN selects emergency-stop support.
REQ-029 Defined: extra port estop input 1, level-sensitive, active-high.
REQ-030 Defined: estop high forces HALT next cycle from any state; moving 0, door_open 0, idle 0, current_floor held, timers frozen, pending still latches; on estop low, HALT -> IDLE next cycle, timers cleared.
REQ-031 Not defined: no estop port, no HALT state, behaviour exactly REQ-014..025.

Verification (NUM_FLOORS=8, MOVE_TICKS=4, DOOR_TICKS=3)
REQ-032 Reset pulse -> current_floor 0, idle 1, dir_up 1, pending 8'h00, door_open 0.
REQ-033 At floor 0 idle, req=8'h20 one cycle -> moving at n+2, floor 5 after 20 cycles of travel, door_open for 3 cycles, pending 8'h00, then idle 1.
REQ-034 From floor 0, req 8'h40; at floor 3 inject req 8'h22 -> stops at 5, then 6, then dir_up 0 and stops at 1; pending 8'h00 at end.
REQ-035 Idle at floor 2, req 8'h04 -> door_open at n+2, floor unchanged; req 8'h04 again during dwell -> door held 3 cycles past last req.
REQ-036 Reset asserted while moving at floor 3 with pending 8'h80 -> outputs equal REQ-026 values without waiting for clk.
REQ-037 ELEVATOR_ESTOP_EN: estop high mid-travel between 2 and 3 -> moving 0, floor 2 held; req 8'h01 latches; estop low -> IDLE, resumes up to pending floors, then serves floor 0.
